// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with three-sample majority voting,
// parity/framing/break detection and a first-word-fall-through output FIFO.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 3;
  localparam logic [CW-1:0] S_FIRST   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] S_MID     = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] S_LAST    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;

  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop0, ferr;
  logic                 maj, decide, wrap, push, brk, push_perr, push_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // The third sample is taken live at the decision point, so only two are stored.
  always_comb begin
    maj       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    decide    = (cnt == S_LAST);
    wrap      = (cnt == CNT_MAX);
    brk       = (shreg == '0) && (PARITY == 0 || !par_bit) &&
                ((STOP_BITS == 1) ? !maj : !stop0);
    push_ferr = ferr | ~maj;
    push_perr = 1'b0;
    if (PARITY == 1)
      push_perr = ~(^shreg ^ par_bit);
    else if (PARITY == 2)
      push_perr = ^shreg ^ par_bit;
    push    = 1'b0;
    state_n = state;
    case (state)
      IDLE:      if (!rxs) state_n = START;
      START: begin
        if (decide && maj) state_n = IDLE;
        else if (wrap)     state_n = DATA;
      end
      DATA:      if (wrap && bit_cnt == DATA_LAST) state_n = (PARITY != 0) ? PAR_BIT : STOP;
      PAR_BIT:   if (wrap) state_n = STOP;
      STOP: begin
        if (decide && bit_cnt == STOP_LAST) begin
          push    = 1'b1;
          state_n = brk ? WAIT_HIGH : IDLE;
        end
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The IDLE cycle that sees the low start edge counts as cnt=0 of the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      shreg   <= '0;
      par_bit <= 1'b0;
      stop0   <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (cnt == S_FIRST) samp0 <= rxs;
      if (cnt == S_MID)   samp1 <= rxs;
      if (state_n == IDLE || state_n == WAIT_HIGH) cnt <= '0;
      else if (state == IDLE)                      cnt <= CW'(1);
      else if (wrap)                               cnt <= '0;
      else                                         cnt <= cnt + CW'(1);
      if (state_n != state) bit_cnt <= '0;
      else if (wrap)        bit_cnt <= bit_cnt + 4'd1;
      if (state == IDLE) ferr <= 1'b0;
      if (decide) begin
        case (state)
          DATA:    shreg   <= {maj, shreg[DATA_BITS-1:1]};
          PAR_BIT: par_bit <= maj;
          STOP: begin
            if (!maj)            ferr  <= 1'b1;
            if (bit_cnt == 4'd0) stop0 <= maj;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [PW:0]   count, remain, count_n;
  logic [EW-1:0] push_entry, head_n;
  logic          full, do_pop, do_push;

  // When no older entry survives this cycle, the incoming frame becomes the new head directly.
  always_comb begin
    push_entry = {shreg, push_perr & ~brk, push_ferr, brk};
    full       = (count == DEPTH_C);
    do_pop     = valid & ready;
    do_push    = push & (~full | do_pop);
    rd_next    = rd_ptr + PW'(do_pop);
    remain     = count - {{PW{1'b0}}, do_pop};
    count_n    = remain + {{PW{1'b0}}, do_push};
    if (remain == '0) head_n = push_entry;
    else              head_n = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid      <= 1'b0;
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_next;
      count   <= count_n;
      overrun <= push & full & ~do_pop;
      valid   <= (count_n != '0);
      if (count_n != '0) {dout, parity_err, frame_err, break_det} <= head_n;
      else               {dout, parity_err, frame_err, break_det} <= '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a frame-level queue model is compared every cycle, and
// directed checks pin latency, glitch rejection, parity, break, overrun and reset.
module tb_uart_rx_fifo;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  // synchroniser + bits ahead of the stop bit + mid-bit decision + output register
  localparam int LAT   = 2 + 9 * OS + (OS / 2 + 1) + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } entry_t;

  typedef struct {
    int     edge_i;
    entry_t e;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  logic ready_fix = 1'b0;
  logic rand_ready = 1'b0;
  logic rand_mode = 1'b0;
  logic ready;
  logic [7:0] dout, dout_p;
  logic valid, parity_err, frame_err, break_det, overrun, busy;
  logic valid_p, parity_err_p, frame_err_p, break_det_p, overrun_p, busy_p;

  assign ready = rand_mode ? rand_ready : ready_fix;

  uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .dout(dout), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .busy(busy));

  uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_par (
    .clk(clk), .rst(rst), .rx(rx_p), .dout(dout_p), .valid(valid_p), .ready(1'b1),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .break_det(break_det_p),
    .overrun(overrun_p), .busy(busy_p));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit checking = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: frames land at their computed edge; FIFO is a plain queue.
  entry_t mq[$];
  pend_t  pend[$];
  bit     exp_ovr = 0;
  bit     m_pop, m_push;
  entry_t m_new;

  always @(posedge clk) begin
    cyc++;
    exp_ovr = 0;
    if (rst) begin
      mq.delete();
      pend.delete();
    end else begin
      m_pop  = (mq.size() > 0) && (ready === 1'b1);
      m_push = 0;
      if (pend.size() > 0 && pend[0].edge_i == cyc) begin
        m_push = 1;
        m_new  = pend[0].e;
        void'(pend.pop_front());
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_new);
        else exp_ovr = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("valid", valid, mq.size() > 0);
      if (mq.size() > 0) begin
        checkOutput("dout", dout, mq[0].data);
        checkOutput("parity_err", parity_err, mq[0].pe);
        checkOutput("frame_err", frame_err, mq[0].fe);
        checkOutput("break_det", break_det, mq[0].bd);
      end
      checkOutput("overrun", overrun, exp_ovr);
    end
  end

  entry_t popped[$];
  int     pop_cyc[$];
  int     ovr_count = 0;
  int     ovr_cyc = 0;
  int     busy_cycles = 0;
  int     par_pops = 0;
  entry_t par_last;

  always @(negedge clk) begin
    if (checking) begin
      if (valid && ready) begin
        popped.push_back({dout, parity_err, frame_err, break_det});
        pop_cyc.push_back(cyc);
      end
      if (overrun) begin
        ovr_count++;
        ovr_cyc = cyc;
      end
      if (busy) busy_cycles++;
      if (valid_p) begin
        par_pops++;
        par_last = {dout_p, parity_err_p, frame_err_p, break_det_p};
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rand_ready = 1'($urandom_range(0, 1));
  end

  int last_fall = 0;

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic v, input int n);
    rx = v;
    waitCycles(n);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop_val, input int gap);
    pend_t p;
    logic  brk;
    brk        = (d == 8'h00) && !stop_val;
    p.edge_i   = cyc + LAT;
    p.e.data   = d;
    p.e.pe     = 1'b0;
    p.e.fe     = !stop_val;
    p.e.bd     = brk;
    pend.push_back(p);
    last_fall = cyc;
    driveBit(1'b0, OS);
    for (int i = 0; i < 8; i++) driveBit(d[i], OS);
    driveBit(stop_val, OS);
    driveBit(1'b1, gap);
  endtask

  task automatic sendBreak(input int low_cycles);
    pend_t p;
    p.edge_i = cyc + LAT;
    p.e      = {8'h00, 1'b0, 1'b1, 1'b1};
    pend.push_back(p);
    driveBit(1'b0, low_cycles);
  endtask

  task automatic sendParFrame(input logic [7:0] d, input logic pbit);
    logic [10:0] bits;
    bits = {1'b1, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_p = bits[i];
      waitCycles(OS);
    end
    rx_p = 1'b1;
    waitCycles(20);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0, o0, b0, p0, fall5;
    logic [7:0] d;
    logic       sv;
    int         gap;

    rst = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_flags", {parity_err, frame_err, break_det, overrun}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_busy_p", {busy_p, overrun_p, valid_p}, 0);
    checking = 1;
    waitCycles(5);

    // Basic 8N1 frame with latency pinned by hand.
    ready_fix = 1'b1;
    n0 = popped.size();
    applyStimulus(8'hA5, 1'b1, 20);
    checkOutput("a5_count", popped.size() - n0, 1);
    if (popped.size() > n0) begin
      checkOutput("a5_entry", popped[n0], {8'hA5, 3'b000});
      checkOutput("a5_latency", pop_cyc[n0] - last_fall, 156);
    end

    // Short low glitch must be rejected quickly.
    b0 = busy_cycles;
    n0 = popped.size();
    driveBit(1'b0, 4);
    driveBit(1'b1, 40);
    checkOutput("glitch_busy_max", (busy_cycles - b0) <= 10, 1);
    checkOutput("glitch_busy_seen", (busy_cycles - b0) > 0, 1);
    checkOutput("glitch_no_push", popped.size() - n0, 0);
    applyStimulus(8'h3C, 1'b1, 20);
    checkOutput("after_glitch", popped[popped.size() - 1], {8'h3C, 3'b000});

    // Even parity on the second instance.
    p0 = par_pops;
    sendParFrame(8'h07, 1'b0);
    checkOutput("par_bad_count", par_pops - p0, 1);
    checkOutput("par_bad_entry", par_last, {8'h07, 3'b100});
    sendParFrame(8'h07, 1'b1);
    checkOutput("par_good_count", par_pops - p0, 2);
    checkOutput("par_good_entry", par_last, {8'h07, 3'b000});

    // Framing error, then a break, then recovery.
    applyStimulus(8'h3C, 1'b0, 20);
    checkOutput("ferr_entry", popped[popped.size() - 1], {8'h3C, 3'b010});
    n0 = popped.size();
    sendBreak(2 * 10 * OS);
    checkOutput("break_count", popped.size() - n0, 1);
    checkOutput("break_entry", popped[popped.size() - 1], {8'h00, 3'b011});
    checkOutput("break_wait_busy", busy, 1);
    driveBit(1'b1, 40);
    checkOutput("break_released", busy, 0);
    applyStimulus(8'h55, 1'b1, 20);
    checkOutput("after_break", popped[popped.size() - 1], {8'h55, 3'b000});

    // Overrun: five back-to-back frames into a four-entry FIFO.
    ready_fix = 1'b0;
    o0 = ovr_count;
    fall5 = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) fall5 = cyc;
      applyStimulus(8'(i), 1'b1, (i == 5) ? 20 : 0);
    end
    checkOutput("ovr_pulses", ovr_count - o0, 1);
    checkOutput("ovr_time", ovr_cyc - fall5, 156);
    n0 = popped.size();
    ready_fix = 1'b1;
    waitCycles(10);
    checkOutput("drain_count", popped.size() - n0, 4);
    for (int i = 0; i < 4; i++)
      if (popped.size() > n0 + i)
        checkOutput("drain_order", popped[n0 + i].data, i + 1);
    checkOutput("drain_valid", valid, 0);

    // Reset mid-DATA with an entry already buffered.
    ready_fix = 1'b0;
    applyStimulus(8'h11, 1'b1, 20);
    checkOutput("pre_rst_valid", valid, 1);
    driveBit(1'b0, OS);
    driveBit(1'b1, OS);
    driveBit(1'b0, 5);
    rst = 1'b1;
    rx  = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_out", {dout, parity_err, frame_err, break_det, overrun}, 0);
    waitCycles(40);
    ready_fix = 1'b1;
    n0 = popped.size();
    applyStimulus(8'h81, 1'b1, 20);
    checkOutput("post_rst_count", popped.size() - n0, 1);
    checkOutput("post_rst_entry", popped[popped.size() - 1], {8'h81, 3'b000});

    // Randomised frames with a random consumer.
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      gap = sv ? $urandom_range(0, 30) : $urandom_range(16, 40);
      applyStimulus(d, sv, gap);
    end
    rand_mode = 1'b0;
    ready_fix = 1'b1;
    for (int i = 0; i < 2000 && (pend.size() > 0 || mq.size() > 0); i++) waitCycles(1);
    checkOutput("final_drained", (pend.size() == 0) && (mq.size() == 0), 1);
    waitCycles(5);
    checkOutput("final_valid", valid, 0);

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
